// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one ripple-carry adder among NREQ valid/ready requesters.
// Optional multi-word carry chaining with requester lock: ADD_SHARE_ARB_CHAIN_EN.
module add_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16,
  parameter int unsigned IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [NREQ-1:0]     req_last,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_sum,
  output logic                rsp_cout,
  output logic [IDW-1:0]      rsp_id
);

`ifdef ADD_SHARE_ARB_CHAIN_EN
  typedef enum logic [1:0] {IDLE, FULL, LOCK} state_e;
`else
  typedef enum logic {IDLE, FULL} state_e;
`endif

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_sum_q, rsp_sum_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic           win_valid;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] win_next;
  logic           load_ok;
  logic           xfer;
  logic [W-1:0]   op_a, op_b, sum;
  logic           cin, cout;

`ifdef ADD_SHARE_ARB_CHAIN_EN
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic           cc_q, cc_d;
  logic           locked;
  logic           win_last;

  assign locked = (state_q == LOCK);
  assign cin    = locked & cc_q;
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign cin         = 1'b0;
`endif

  // Round-robin search from rr_ptr; a held chain pins the grant to its owner.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_valid = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!win_valid && (idx == i) && req_valid[i]) begin
          win_valid = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end
`ifdef ADD_SHARE_ARB_CHAIN_EN
    if (locked) begin
      win_valid = 1'b0;
      win_id    = lock_id_q;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (lock_id_q == IDW'(i)) win_valid = req_valid[i];
      end
    end
`endif
  end

  assign load_ok  = !rsp_valid_q | rsp_ready;
  assign xfer     = win_valid & load_ok & !rst;
  assign win_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

  // Operand steering into the single shared adder.
  always_comb begin
    op_a = '0;
    op_b = '0;
`ifdef ADD_SHARE_ARB_CHAIN_EN
    win_last = 1'b1;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        op_a = req_a[i*W +: W];
        op_b = req_b[i*W +: W];
`ifdef ADD_SHARE_ARB_CHAIN_EN
        win_last = req_last[i];
`endif
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = xfer && (win_id == IDW'(i));
    end
  end

  // Shared ripple-carry adder.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int unsigned i = 0; i < W; i++) begin
      sum[i] = op_a[i] ^ op_b[i] ^ c;
      c      = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
    end
    cout = c;
  end

  // Next state, output stage and arbitration bookkeeping.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
`ifdef ADD_SHARE_ARB_CHAIN_EN
    lock_id_d   = lock_id_q;
    cc_d        = cc_q;
`endif

    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = sum;
      rsp_cout_d  = cout;
      rsp_id_d    = win_id;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: if (xfer) state_d = FULL;
      FULL: if (!xfer && rsp_ready) state_d = IDLE;
`ifdef ADD_SHARE_ARB_CHAIN_EN
      LOCK: if (xfer && win_last) state_d = FULL;
`endif
      default: state_d = IDLE;
    endcase

`ifdef ADD_SHARE_ARB_CHAIN_EN
    if (xfer) begin
      if (win_last) begin
        rr_ptr_d = win_next;
        cc_d     = 1'b0;
      end else begin
        state_d   = LOCK;
        lock_id_d = win_id;
        cc_d      = cout;
      end
    end
`else
    if (xfer) rr_ptr_d = win_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
`ifdef ADD_SHARE_ARB_CHAIN_EN
      lock_id_q   <= '0;
      cc_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
`ifdef ADD_SHARE_ARB_CHAIN_EN
      lock_id_q   <= lock_id_d;
      cc_q        <= cc_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: directed scenarios plus random traffic against a cycle-level model.
module tb_add_share_arb;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 16;
  localparam int unsigned IDW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid, req_ready, req_last;
  logic [NREQ*W-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [W-1:0]    rsp_sum;
  logic            rsp_cout;
  logic [IDW-1:0]  rsp_id;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_valid;
  int m_sum, m_cout, m_id, m_ptr, m_lock, m_cc;

  always #5 clk = ~clk;

  add_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_sum   = 0;
    m_cout  = 0;
    m_id    = 0;
    m_ptr   = 0;
    m_lock  = -1;
    m_cc    = 0;
  endtask

  // One clock: inputs are already driven; check ready, advance model, check response.
  task automatic cycle();
    int w;
    int s;
    int cin;
    bit lok;
    logic [NREQ-1:0] er;
    #1;
    w = -1;
    if (!rst) begin
      if (m_lock >= 0) begin
        if (req_valid[2'(m_lock)]) w = m_lock;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && req_valid[2'(idx)]) w = idx;
        end
      end
    end
    lok = !m_valid || rsp_ready;
    if (!lok) w = -1;
    er = (w >= 0) ? NREQ'(1 << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (w >= 0) begin
      cin = (m_lock >= 0) ? m_cc : 0;
      s = int'(req_a[w*W +: W]) + int'(req_b[w*W +: W]) + cin;
      m_sum   = s % 65536;
      m_cout  = s / 65536;
      m_id    = w;
      m_valid = 1'b1;
`ifdef ADD_SHARE_ARB_CHAIN_EN
      if (!req_last[2'(w)]) begin
        m_lock = w;
        m_cc   = m_cout;
      end else begin
        m_lock = -1;
        m_cc   = 0;
        m_ptr  = (w + 1) % NREQ;
      end
`else
      m_ptr = (w + 1) % NREQ;
`endif
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_sum",   32'(rsp_sum),   32'(m_sum));
    chk("rsp_cout",  32'(rsp_cout),  32'(m_cout));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    @(negedge clk);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'($urandom);
      req_b[i*W +: W] = W'($urandom);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset with all requesters valid: nothing may be granted or reported.
    req_valid = '1;
    rand_ops();
    cycle();
    cycle();
    chk("reset_valid", 32'(rsp_valid), 32'(0));
    chk("reset_sum", 32'(rsp_sum), 32'(0));

    // Single beat with carry out.
    rst       = 1'b0;
    req_valid = 4'b0001;
    req_a[0 +: W] = 16'hFFFF;
    req_b[0 +: W] = 16'h0001;
    cycle();
    chk("single_sum", 32'(rsp_sum), 32'(16'h0000));
    chk("single_cout", 32'(rsp_cout), 32'(1));
    chk("single_id", 32'(rsp_id), 32'(0));
    req_valid = '0;
    cycle();

    // Fairness from a fresh pointer.
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    req_valid = '1;
    req_last  = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      cycle();
      chk("rr_seq", 32'(rsp_id), 32'(i % NREQ));
    end

    // Backpressure: result held, no grants.
    req_valid = 4'b0100;
    req_a[2*W +: W] = 16'h1234;
    req_b[2*W +: W] = 16'h4321;
    cycle();
    chk("bp_load", 32'(rsp_sum), 32'(16'h5555));
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold", 32'(rsp_sum), 32'(16'h5555));
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_release", 32'(rsp_id), 32'(3));

    // Sparse requesters starting from pointer 2.
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'b1010;
    cycle();
    chk("sparse0", 32'(rsp_id), 32'(3));
    cycle();
    chk("sparse1", 32'(rsp_id), 32'(1));
    cycle();
    chk("sparse2", 32'(rsp_id), 32'(3));

`ifdef ADD_SHARE_ARB_CHAIN_EN
    // Two-word chain on req1 with req0 waiting.
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    req_last  = '1;
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b0011;
    req_last[1] = 1'b0;
    req_a[W +: W] = 16'hFFFF;
    req_b[W +: W] = 16'h0001;
    cycle();
    chk("chain_w0_sum", 32'(rsp_sum), 32'(16'h0000));
    chk("chain_w0_cout", 32'(rsp_cout), 32'(1));
    chk("chain_w0_id", 32'(rsp_id), 32'(1));
    req_last[1] = 1'b1;
    req_a[W +: W] = 16'h0000;
    req_b[W +: W] = 16'h0000;
    cycle();
    chk("chain_w1_sum", 32'(rsp_sum), 32'(16'h0001));
    chk("chain_w1_cout", 32'(rsp_cout), 32'(0));
    chk("chain_w1_id", 32'(rsp_id), 32'(1));
    req_valid = 4'b0001;
    cycle();
    chk("chain_next", 32'(rsp_id), 32'(0));

    // Reset mid-chain clears lock and carry.
    req_valid   = 4'b0010;
    req_last[1] = 1'b0;
    req_a[W +: W] = 16'hFFFF;
    req_b[W +: W] = 16'h0001;
    cycle();
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    req_last  = '1;
    req_valid = 4'b0011;
    req_a     = '0;
    req_b     = '0;
    cycle();
    chk("midrst_id", 32'(rsp_id), 32'(0));
    chk("midrst_cin", 32'(rsp_sum), 32'(0));
`endif

    // Random traffic with occasional reset and backpressure.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      req_valid = NREQ'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) req_last[i] = ($urandom_range(0, 2) != 0);
      rand_ops();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
